// File: rtl/lc3_core_if.sv
// Shared RAM port of the LC-3 core: one address/data path with enable and write strobe.
interface lc3_core_if;
    logic [15:0] mem_data;
    logic [15:0] ram_data;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        we;

    modport master (input mem_data, output ram_data, mem_addr, mem_en, we);
    modport slave  (output mem_data, input ram_data, mem_addr, mem_en, we);
endinterface

// File: rtl/lc3_core.sv
// Multicycle, non-pipelined LC-3 core on a single-port synchronous RAM.
// Optional macro LC3_HALT_EN: TRAP x25 parks the core in HALT until reset.
module lc3_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    lc3_core_if.master bus
);

    typedef enum logic [2:0] {FETCH, LOADIR, EXEC, MEMRD, MEMWB, MEMWR, HALT} state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] mar;
    logic [15:0] r [8];
    logic [2:0]  cc;
    logic        ind_pass;

    logic [3:0]  opcode;
    logic [15:0] imm5, off6, off9, off11;
    logic [15:0] sr1_val, src2, dr_val;
    logic [15:0] pc_off9, pc_off11, base_off6;
    logic [15:0] add_res, and_res, not_res;
    logic        br_taken;

    assign opcode    = ir[15:12];
    assign imm5      = {{11{ir[4]}}, ir[4:0]};
    assign off6      = {{10{ir[5]}}, ir[5:0]};
    assign off9      = {{7{ir[8]}}, ir[8:0]};
    assign off11     = {{5{ir[10]}}, ir[10:0]};
    assign sr1_val   = r[ir[8:6]];
    assign src2      = ir[5] ? imm5 : r[ir[2:0]];
    assign dr_val    = r[ir[11:9]];
    assign pc_off9   = pc + off9;
    assign pc_off11  = pc + off11;
    assign base_off6 = sr1_val + off6;
    assign add_res   = sr1_val + src2;
    assign and_res   = sr1_val & src2;
    assign not_res   = ~sr1_val;
    assign br_taken  = (ir[11] & cc[2]) | (ir[10] & cc[1]) | (ir[9] & cc[0]);

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Whole datapath and sequencing; ind_pass marks the pointer-fetch pass of LDI/STI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            mar      <= '0;
            r        <= '{default: '0};
            cc       <= 3'b010;
            ind_pass <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= LOADIR;
                LOADIR: begin
                    ir    <= bus.mem_data;
                    pc    <= pc + 16'd1;
                    state <= EXEC;
                end
                EXEC: begin
                    state    <= FETCH;
                    ind_pass <= 1'b0;
                    case (opcode)
                        OP_ADD: begin
                            r[ir[11:9]] <= add_res;
                            cc          <= cc_of(add_res);
                        end
                        OP_AND: begin
                            r[ir[11:9]] <= and_res;
                            cc          <= cc_of(and_res);
                        end
                        OP_NOT: begin
                            r[ir[11:9]] <= not_res;
                            cc          <= cc_of(not_res);
                        end
                        OP_BR: begin
                            if (br_taken)
                                pc <= pc_off9;
                        end
                        OP_JMP: pc <= sr1_val;
                        // Target is taken from the pre-write base so JSRR R7 uses old R7.
                        OP_JSR: begin
                            r[7] <= pc;
                            pc   <= ir[11] ? pc_off11 : sr1_val;
                        end
                        OP_LEA: r[ir[11:9]] <= pc_off9;
                        OP_LD: begin
                            mar   <= pc_off9;
                            state <= MEMRD;
                        end
                        OP_LDR: begin
                            mar   <= base_off6;
                            state <= MEMRD;
                        end
                        OP_LDI, OP_STI: begin
                            mar      <= pc_off9;
                            ind_pass <= 1'b1;
                            state    <= MEMRD;
                        end
                        OP_ST: begin
                            mar   <= pc_off9;
                            state <= MEMWR;
                        end
                        OP_STR: begin
                            mar   <= base_off6;
                            state <= MEMWR;
                        end
                        OP_TRAP: begin
`ifdef LC3_HALT_EN
                            if (ir[7:0] == 8'h25) begin
                                state <= HALT;
                            end else begin
                                r[7]  <= pc;
                                mar   <= {8'h00, ir[7:0]};
                                state <= MEMRD;
                            end
`else
                            r[7]  <= pc;
                            mar   <= {8'h00, ir[7:0]};
                            state <= MEMRD;
`endif
                        end
                        default: ;
                    endcase
                end
                MEMRD: state <= MEMWB;
                MEMWB: begin
                    if (ind_pass) begin
                        mar      <= bus.mem_data;
                        ind_pass <= 1'b0;
                        state    <= (opcode == OP_STI) ? MEMWR : MEMRD;
                    end else if (opcode == OP_TRAP) begin
                        pc    <= bus.mem_data;
                        state <= FETCH;
                    end else begin
                        r[ir[11:9]] <= bus.mem_data;
                        cc          <= cc_of(bus.mem_data);
                        state       <= FETCH;
                    end
                end
                MEMWR: state <= FETCH;
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Bus is decoded from the current state; reset forces an idle bus parked at RESET_PC.
    assign bus.mem_en   = !rst && (state == FETCH || state == MEMRD || state == MEMWR);
    assign bus.we       = !rst && (state == MEMWR);
    assign bus.mem_addr = rst ? RESET_PC : ((state == FETCH) ? pc : mar);
    assign bus.ram_data = (!rst && state == MEMWR) ? dr_val : 16'h0000;

endmodule

// File: tb/tb_lc3_core.sv
// Scoreboard bench for lc3_core: an ISA-level model predicts every bus access and its cycle.
// Honours LC3_HALT_EN the same way the core does.
module tb_lc3_core;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic        we;
        logic [15:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lc3_core_if bus();

    lc3_core #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram     [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] rd_q = 16'h0000;
    int          copy_req  = 0;
    int          copy_done = 0;

    txn_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   model_halted = 1'b0;

    assign bus.mem_data = rd_q;

    // Synchronous RAM; also takes a snapshot of the model memory when a new test is loaded.
    always @(posedge clk) begin
        if (copy_req != copy_done) begin
            for (int a = 0; a < 65536; a++)
                ram[a] <= ref_mem[a];
            copy_done <= copy_req;
        end else if (bus.mem_en) begin
            if (bus.we)
                ram[bus.mem_addr] <= bus.ram_data;
            else
                rd_q <= ram[bus.mem_addr];
        end
    end

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic signed [15:0] s;
        s = $signed(v << (16 - bits));
        return 16'(s >>> (16 - bits));
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    task automatic push_txn(input int c, input logic [15:0] a, input logic w, input logic [15:0] d);
        txn_t t;
        t.cyc = c; t.addr = a; t.we = w; t.data = d;
        exp_q.push_back(t);
    endtask

    // Executes n instructions at ISA level on ref_mem, queueing the expected bus traffic.
    task automatic run_model(input int n);
        logic [15:0] rf [8];
        logic [15:0] pc, ir, a, b, res, addr, ptr;
        logic [2:0]  cc;
        logic [3:0]  op;
        bit          halt_hit;
        int          t;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        pc = RESET_PC; cc = 3'b010; t = 1; model_halted = 1'b0;
        for (int i = 0; i < n && !model_halted; i++) begin
            push_txn(t, pc, 1'b0, 16'h0000);
            ir = ref_mem[pc];
            pc = pc + 16'd1;
            op = ir[15:12];
            case (op)
                4'h1, 4'h5: begin
                    a = rf[ir[8:6]];
                    b = ir[5] ? sx(ir, 5) : rf[ir[2:0]];
                    res = (op == 4'h1) ? a + b : a & b;
                    rf[ir[11:9]] = res; cc = nzp_of(res); t += 3;
                end
                4'h9: begin
                    res = ~rf[ir[8:6]];
                    rf[ir[11:9]] = res; cc = nzp_of(res); t += 3;
                end
                4'h0: begin
                    if ((ir[11] && cc[2]) || (ir[10] && cc[1]) || (ir[9] && cc[0]))
                        pc = pc + sx(ir, 9);
                    t += 3;
                end
                4'hC: begin pc = rf[ir[8:6]]; t += 3; end
                4'h4: begin
                    addr = ir[11] ? pc + sx(ir, 11) : rf[ir[8:6]];
                    rf[7] = pc; pc = addr; t += 3;
                end
                4'hE: begin rf[ir[11:9]] = pc + sx(ir, 9); t += 3; end
                4'h2, 4'h6: begin
                    addr = (op == 4'h2) ? pc + sx(ir, 9) : rf[ir[8:6]] + sx(ir, 6);
                    push_txn(t + 3, addr, 1'b0, 16'h0000);
                    res = ref_mem[addr];
                    rf[ir[11:9]] = res; cc = nzp_of(res); t += 5;
                end
                4'hA: begin
                    addr = pc + sx(ir, 9);
                    push_txn(t + 3, addr, 1'b0, 16'h0000);
                    ptr = ref_mem[addr];
                    push_txn(t + 5, ptr, 1'b0, 16'h0000);
                    res = ref_mem[ptr];
                    rf[ir[11:9]] = res; cc = nzp_of(res); t += 7;
                end
                4'h3, 4'h7: begin
                    addr = (op == 4'h3) ? pc + sx(ir, 9) : rf[ir[8:6]] + sx(ir, 6);
                    push_txn(t + 3, addr, 1'b1, rf[ir[11:9]]);
                    ref_mem[addr] = rf[ir[11:9]]; t += 4;
                end
                4'hB: begin
                    addr = pc + sx(ir, 9);
                    push_txn(t + 3, addr, 1'b0, 16'h0000);
                    ptr = ref_mem[addr];
                    push_txn(t + 5, ptr, 1'b1, rf[ir[11:9]]);
                    ref_mem[ptr] = rf[ir[11:9]]; t += 6;
                end
                4'hF: begin
`ifdef LC3_HALT_EN
                    halt_hit = (ir[7:0] == 8'h25);
`else
                    halt_hit = 1'b0;
`endif
                    if (halt_hit) begin
                        model_halted = 1'b1;
                    end else begin
                        rf[7] = pc;
                        addr = {8'h00, ir[7:0]};
                        push_txn(t + 3, addr, 1'b0, 16'h0000);
                        pc = ref_mem[addr]; t += 5;
                    end
                end
                default: t += 3;
            endcase
        end
        if (!model_halted)
            push_txn(t, pc, 1'b0, 16'h0000);
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) ref_mem[a] = 16'h0000;
    endtask

    task automatic random_mem();
        for (int a = 0; a < 65536; a++) ref_mem[a] = 16'($urandom);
    endtask

    // Loads ref_mem into the RAM under reset, checks the reset bus, then runs n instructions.
    task automatic apply_stimulus(input int n);
        int waited;
        rst = 1'b1;
        copy_req++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("reset_mem_en", {15'd0, bus.mem_en}, 16'h0000);
        check_output("reset_we", {15'd0, bus.we}, 16'h0000);
        check_output("reset_ram_data", bus.ram_data, 16'h0000);
        check_output("reset_mem_addr", bus.mem_addr, RESET_PC);
        run_model(n);
        @(posedge clk);
        #1 rst = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 7 * n + 50) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL timeout: %0d accesses still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        if (model_halted) begin
            repeat (20) begin
                @(negedge clk);
                check_output("halt_idle_mem_en", {15'd0, bus.mem_en}, 16'h0000);
            end
        end
        #1 rst = 1'b1;
    endtask

    initial begin
        fork
            begin
                clear_mem();
                ref_mem[0] = 16'h5020; ref_mem[1] = 16'h1025; ref_mem[2] = 16'h3002;
                apply_stimulus(3);

                clear_mem();
                ref_mem[0] = 16'h2203; ref_mem[1] = 16'h0801; ref_mem[4] = 16'hFFFF;
                apply_stimulus(2);

                clear_mem();
                ref_mem[0] = 16'hA401; ref_mem[2] = 16'h0010; ref_mem[16] = 16'h1234;
                ref_mem[1] = 16'h3500;
                apply_stimulus(2);

                clear_mem();
                ref_mem[0] = 16'h4803; ref_mem[4] = 16'hC1C0;
                apply_stimulus(2);

                clear_mem();
                ref_mem[0] = 16'hF025; ref_mem[16'h25] = 16'h0040; ref_mem[16'h40] = 16'h3E00;
                apply_stimulus(2);

                for (int k = 0; k < 8; k++) begin
                    random_mem();
                    apply_stimulus(40);
                end
            end
            begin : monitor
                int   cyc;
                txn_t e;
                cyc = 1;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        cyc = 1;
                    end else begin
                        if (bus.mem_en) begin
                            if (exp_q.size() == 0) begin
                                total++; bad++;
                                $display("[TB] FAIL unexpected_access: cyc=%0d addr=%h we=%b, required no access",
                                         cyc, bus.mem_addr, bus.we);
                            end else begin
                                e = exp_q.pop_front();
                                total++;
                                if (cyc != e.cyc || bus.mem_addr !== e.addr || bus.we !== e.we ||
                                    bus.ram_data !== e.data) begin
                                    bad++;
                                    $display("[TB] FAIL bus_txn: got cyc=%0d addr=%h we=%b data=%h, required cyc=%0d addr=%h we=%b data=%h",
                                             cyc, bus.mem_addr, bus.we, bus.ram_data, e.cyc, e.addr, e.we, e.data);
                                end
                            end
                        end
                        cyc++;
                    end
                end
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_core.md
Name: lc3_core

Overview:
- Multicycle LC-3 ISA processor core, one instruction at a time, non-pipelined.
- Talks to a single-port synchronous RAM over one shared address/data interface: mem_en, we, mem_addr, write data out, read data in.
- Sits at the top of the CPU subsystem. The RAM is a separate block; program and data share the RAM.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (first instruction fetched from this address).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset.
- mem_data  input  16  RAM read data, valid the cycle after a read request (mem_en=1, we=0).
- ram_data  output  16  RAM write data.
- mem_addr  output  16  RAM word address.
- mem_en  output  1  RAM access enable.
- we  output  1  RAM write enable, meaningful only with mem_en=1.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- State: PC, IR, MAR, R0–R7 (16b each), CC {N,Z,P}, FSM state, indirect-pass flag.
- Reset (rst=1 at posedge):
  - PC=RESET_PC; IR, MAR, R0–R7 = 0; CC=Z (3'b010); state=FETCH.
  - Outputs while in reset: mem_en=0, we=0, ram_data=0, mem_addr=RESET_PC.
  - Reset mid-instruction aborts it; no partial register write.
- Outputs are combinational from state and registers (Moore).
- FETCH: mem_en=1, we=0, mem_addr=PC. Next state LOADIR.
- LOADIR: IR<=mem_data; PC<=PC+1. Next state EXEC.
- EXEC, by IR[15:12]:
  - ADD(0001), AND(0101): src2 = IR[5] ? sext(IR[4:0]) : R[IR[2:0]]. DR=R[IR[11:9]]; write result, set CC; go FETCH.
  - NOT(1001): DR=~R[IR[8:6]]; set CC; go FETCH.
  - BR(0000): if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), PC<=PC+sext(IR[8:0]). Go FETCH. Encoding 0x0000 is a NOP.
  - JMP/RET(1100): PC<=R[IR[8:6]]; go FETCH.
  - JSR/JSRR(0100): target = IR[11] ? PC+sext(IR[10:0]) : R[IR[8:6]]. Target uses the base register value before R7 is written, so JSRR R7 jumps to old R7. Then R7<=PC, PC<=target; go FETCH.
  - LEA(1110): DR<=PC+sext(IR[8:0]); CC unchanged; go FETCH.
  - LD(0010) and LDI(1010): MAR<=PC+sext(IR[8:0]). LDR(0110): MAR<=R[IR[8:6]]+sext(IR[5:0]). All three go MEMRD.
  - ST(0011): MAR<=PC+sext(IR[8:0]); go MEMWR. STR(0111): MAR<=R[IR[8:6]]+sext(IR[5:0]); go MEMWR.
  - STI(1011): MAR<=PC+sext(IR[8:0]); go MEMRD.
  - TRAP(1111): R7<=PC, MAR<={8'h00,IR[7:0]}; go MEMRD.
  - RTI(1000), reserved(1101): NOP, go FETCH.
- MEMRD: mem_en=1, we=0, mem_addr=MAR. Next state MEMWB.
- MEMWB:
  - LDI/STI first pass: MAR<=mem_data. LDI then goes MEMRD; STI goes MEMWR.
  - TRAP: PC<=mem_data.
  - Otherwise: DR<=mem_data, set CC.
  - Then go FETCH.
- MEMWR: mem_en=1, we=1, mem_addr=MAR, ram_data=R[IR[11:9]]. Next state FETCH.
- ram_data is 0 outside MEMWR.
- CC rule: N = result[15]; Z = (result==0); P = otherwise. Exactly one bit is set.
- Arithmetic: 16-bit two's complement, wraps, no overflow flag. PC increment and address adds wrap at 16'hFFFF->16'h0000.
- Cycle counts, FETCH through last state:
  - ALU/BR/JMP/JSR/LEA: 3.
  - ST/STR: 4.
  - LD/LDR/TRAP: 5.
  - STI: 6.
  - LDI: 7.

Optional Feature:
- Macro LC3_HALT_EN.
- Defined:
  - TRAP with IR[7:0]==8'h25 enters a HALT state instead of the vector read.
  - HALT: mem_en=0, we=0, PC and registers frozen, left only by reset.
  - R7 is not written on HALT.
- Undefined: TRAP x25 behaves like any other TRAP (vector read from address 0x0025).

Test Plan:
- Reset: hold rst=1 4 cycles, release. First cycle: mem_en=1, we=0, mem_addr=0x0000; cycle after: 0x0000 not re-read, LOADIR occurs. CC=010.
- ALU and store program:
  - Program: mem[0]=0x5020 (AND R0,#0), mem[1]=0x1025 (ADD R0,#5), mem[2]=0x3002 (ST R0,#2).
  - Required: write cycle with mem_addr=0x0005, ram_data=0x0005, we=1 at cycle 10 after reset release; CC=P after ADD.
- Load and branch:
  - Program: mem[0]=0x2203 (LD R1,#3), mem[4]=0xFFFF, mem[1]=0x0801 (BRn #1).
  - Required: R1=0xFFFF, CC=N; BR taken, next fetch address 0x0003.
- Indirect:
  - Setup: mem[0]=0xA401 (LDI R2,#1), mem[2]=0x0010, mem[16]=0x1234.
  - Required: reads at 0x0002 then 0x0010; R2=0x1234; 7 cycles.
- Subroutine:
  - Setup: mem[0]=0x4803 (JSR #3).
  - Required: R7=0x0001, next fetch 0x0004. Then mem[4]=0xC1C0 (RET): next fetch 0x0001.
- TRAP x25:
  - With LC3_HALT_EN: mem_en stays 0 forever after.
  - Without: read at 0x0025, PC<=mem[0x25], R7=PC+1.
